// File: rtl/aap_fetch_unit.sv
// rtl/aap_fetch_unit.sv - AAP instruction fetch stage with prefetch FIFO and 16/32-bit assembly
//
// Issues sequential word reads to instruction memory, buffers returned
// halfwords in a DEPTH-entry FIFO and presents whole 16- or 32-bit
// instructions to the decoder. A redirect flushes the FIFO and restarts
// fetch at the branch target.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   imem_req, imem_addr     word read request and word address
//   imem_ack, imem_rdata    read response, exactly one cycle after the request
//   redirect, redirect_pc   taken-branch pulse and target word address
//   dec_valid, dec_ready    instruction handshake towards the decoder
//   dec_instr, dec_is32     assembled instruction and its length
//   dec_pc                  word address of the presented instruction
//   stall_count             decoder-starved cycle counter (FETCH_PERF_EN only)
//
// Optional feature macro: FETCH_PERF_EN adds the stall_count output.

module aap_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic        dec_is32,
  output logic [15:0] dec_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [15:0]   fpc;
  logic [CW-1:0] count;
  logic          inflight;
  logic          drop;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [15:0]   fifo [DEPTH];
  logic [15:0]   head0, head1;
  logic [CW:0]   occupancy;
  logic          enq;
  logic          pop;
  logic [1:0]    pop_n;

  assign imem_addr = fpc;
  assign head0     = fifo[rd_ptr];
  assign head1     = fifo[rd_ptr + AW'(1)];
  // A request still in flight already owns a FIFO slot.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dec_is32  = 1'b0;
    dec_valid = 1'b0;
    dec_instr = 32'h0;
    pop       = 1'b0;
    pop_n     = 2'd0;
    enq       = 1'b0;

    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     imem_req  = !redirect && (occupancy < (CW+1)'(DEPTH));
      default: state_nxt = IDLE;
    endcase

    dec_is32  = (count != '0) && head0[15];
    // A 32-bit head with only its first halfword buffered is not yet valid.
    dec_valid = dec_is32 ? (count >= CW'(2)) : (count != '0);
    if (dec_valid) begin
      dec_instr = dec_is32 ? {head1, head0} : {16'h0, head0};
    end

    pop   = dec_valid && dec_ready && !redirect;
    pop_n = pop ? (dec_is32 ? 2'd2 : 2'd1) : 2'd0;
    // Responses to requests issued before a redirect land in the redirect
    // cycle or the one after it; both are dropped.
    enq   = imem_ack && !redirect && !drop;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      count    <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      dec_pc   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      inflight <= imem_req;
      drop     <= redirect;
      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        fpc    <= redirect_pc;
        dec_pc <= redirect_pc;
      end else begin
        if (imem_req) fpc <= fpc + 16'd1;
        if (enq) wr_ptr <= wr_ptr + AW'(1);
        rd_ptr <= rd_ptr + AW'(pop_n);
        dec_pc <= dec_pc + {14'h0, pop_n};
        count  <= count + CW'(enq) - CW'(pop_n);
      end
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clock) begin
    if (enq) fifo[wr_ptr] <= imem_rdata;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= 16'h0;
    end else if (redirect) begin
      stall_count <= 16'h0;
    end else if (state == RUN && dec_ready && !dec_valid && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
